// File: rtl/stq_pkg.sv
// rtl/stq_pkg.sv - shared store-queue constants, FSM state type and helpers
package stq_pkg;

    localparam int STQ_DEPTH   = 64;
    localparam int STQ_IDX_W   = 6;
    localparam int STQ_PTR_W   = 7;
    localparam int STQ_ADATA_W = 5;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } stq_state_e;

    // Smaller of two 0..3 counts; clamps a retire request to what is retirable.
    function automatic logic [1:0] stq_min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/stq_ring_ptr.sv
// rtl/stq_ring_ptr.sv - wrap-bit ring pointer with 0..2 increment and load
module stq_ring_ptr
    import stq_pkg::*;
#(
    parameter int W = STQ_PTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   inc,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] ptr
);

    // The top bit is the wrap bit; plain modulo-2^W addition handles the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (ld) begin
            ptr <= ld_val;
        end else begin
            ptr <= ptr + W'(inc);
        end
    end

endmodule

// File: rtl/stq_adata_ctl.sv
// rtl/stq_adata_ctl.sv - store-queue address-data allocate/retire controller (optional STQ_ADATA_CTL_PERF_EN)
module stq_adata_ctl
    import stq_pkg::*;
#(
    parameter int DEPTH   = STQ_DEPTH,
    parameter int ADATA_W = STQ_ADATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc0_req,
    input  logic [ADATA_W-1:0]         alloc0_adata,
    input  logic                       alloc1_req,
    input  logic [ADATA_W-1:0]         alloc1_adata,
    input  logic                       flush,
    input  logic [1:0]                 ret_req,
    input  logic [ADATA_W-1:0]         upd0_adata,
    input  logic [ADATA_W-1:0]         upd1_adata,
    output logic                       alloc0_gnt,
    output logic                       alloc1_gnt,
    output logic [$clog2(DEPTH)-1:0]   alloc0_WQ,
    output logic [$clog2(DEPTH)-1:0]   alloc1_WQ,
    output logic                       wrt0_en,
    output logic [$clog2(DEPTH)-1:0]   wrt0_WQ,
    output logic [ADATA_W-1:0]         wrt0_adata,
    output logic                       wrt1_en,
    output logic [$clog2(DEPTH)-1:0]   wrt1_WQ,
    output logic [ADATA_W-1:0]         wrt1_adata,
    output logic [$clog2(DEPTH)-1:0]   upd0_WQ,
    output logic [$clog2(DEPTH)-1:0]   upd1_WQ,
    output logic [1:0]                 ret_vld,
    output logic [1:0]                 ret_cnt,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
`ifdef STQ_ADATA_CTL_PERF_EN
    ,
    output logic [31:0]                perf_stall,
    output logic [31:0]                perf_alloc,
    output logic [15:0]                perf_flush
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    stq_state_e          state_q;
    stq_state_e          state_d;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W-1:0]    head_next;
    logic [PTR_W-1:0]    free;
    logic [IDX_W-1:0]    head_idx;
    logic [IDX_W-1:0]    tail_idx;
    logic [1:0]          tail_inc;
    logic [1:0]          lead;
    logic                blk;
    logic [DEPTH-1:0]    valid;

    logic                w0_en;
    logic [IDX_W-1:0]    w0_wq;
    logic [ADATA_W-1:0]  w0_ad;
    logic                w1_en;
    logic [IDX_W-1:0]    w1_wq;
    logic [ADATA_W-1:0]  w1_ad;

    // Table read data goes straight to the requester; nothing here consumes it.
    logic unused_upd;
    assign unused_upd = ^{upd0_adata, upd1_adata};

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign count    = tail - head;
    assign free     = PTR_W'(DEPTH) - count;
    assign full     = (count == PTR_W'(DEPTH));
    assign empty    = (count == '0);
    assign upd0_WQ  = head_idx;
    assign upd1_WQ  = head_idx + IDX_W'(1);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a flush (held or single) parks in FLUSH for the valid wipe.
    always_comb begin
        state_d = RUN;
        if (flush) begin
            state_d = FLUSH;
        end
    end

    // Grants use the current count, so a same-cycle retire never frees a slot early.
    always_comb begin
        blk        = (state_q == FLUSH) | flush;
        alloc0_gnt = alloc0_req & ~blk & (free != '0);
        alloc1_gnt = alloc1_req & ~blk &
                     (alloc0_req ? (free >= PTR_W'(2)) : (free != '0));
        tail_inc   = {1'b0, alloc0_gnt} + {1'b0, alloc1_gnt};
        alloc0_WQ  = tail_idx;
        alloc1_WQ  = alloc0_gnt ? (tail_idx + IDX_W'(1)) : tail_idx;
    end

    // Retire window: only in-order written entries count; excess requests drop.
    always_comb begin
        ret_vld[0] = (state_q == RUN) & valid[head_idx];
        ret_vld[1] = ret_vld[0] & valid[upd1_WQ];
        lead       = ret_vld[1] ? 2'd2 : (ret_vld[0] ? 2'd1 : 2'd0);
        ret_cnt    = stq_min2(ret_req, lead);
        head_next  = head + PTR_W'(ret_cnt);
    end

    stq_ring_ptr #(.W(PTR_W)) u_head (
        .clk    (clk),
        .rst    (rst),
        .inc    (ret_cnt),
        .ld     (1'b0),
        .ld_val ('0),
        .ptr    (head)
    );

    stq_ring_ptr #(.W(PTR_W)) u_tail (
        .clk    (clk),
        .rst    (rst),
        .inc    (tail_inc),
        .ld     (flush),
        .ld_val (head_next),
        .ptr    (tail)
    );

    // Write stage: granted lanes are captured and issued to the table next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w0_en <= 1'b0;
            w0_wq <= '0;
            w0_ad <= '0;
            w1_en <= 1'b0;
            w1_wq <= '0;
            w1_ad <= '0;
        end else begin
            w0_en <= alloc0_gnt;
            w0_wq <= alloc0_WQ;
            w0_ad <= alloc0_adata;
            w1_en <= alloc1_gnt;
            w1_wq <= alloc1_WQ;
            w1_ad <= alloc1_adata;
        end
    end

    // A flush squashes the write that would otherwise issue in the flush cycle.
    assign wrt0_en    = w0_en & ~flush;
    assign wrt0_WQ    = w0_wq;
    assign wrt0_adata = w0_ad;
    assign wrt1_en    = w1_en & ~flush;
    assign wrt1_WQ    = w1_wq;
    assign wrt1_adata = w1_ad;

    // Valid bits: set when the write issues, clear on retire, wiped in FLUSH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (state_q == FLUSH) begin
            valid <= '0;
        end else begin
            if (ret_cnt != 2'd0) begin
                valid[head_idx] <= 1'b0;
            end
            if (ret_cnt == 2'd2) begin
                valid[upd1_WQ] <= 1'b0;
            end
            if (wrt0_en) begin
                valid[w0_wq] <= 1'b1;
            end
            if (wrt1_en) begin
                valid[w1_wq] <= 1'b1;
            end
        end
    end

`ifdef STQ_ADATA_CTL_PERF_EN
    logic        stall;
    logic [32:0] alloc_sum;

    assign stall     = (alloc0_req & ~alloc0_gnt) | (alloc1_req & ~alloc1_gnt);
    assign alloc_sum = {1'b0, perf_alloc} + 33'(tail_inc);

    // Saturating event counters, frozen while the FSM is in FLUSH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall <= '0;
            perf_alloc <= '0;
            perf_flush <= '0;
        end else if (state_q == RUN) begin
            if (stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            perf_alloc <= alloc_sum[32] ? '1 : alloc_sum[31:0];
            if (flush && (perf_flush != '1)) begin
                perf_flush <= perf_flush + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stq_adata_ctl.sv
// tb/tb_stq_adata_ctl.sv - table-driven and directed self-checking bench for stq_adata_ctl
module tb_stq_adata_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc0_req, alloc1_req, flush;
    logic [4:0] alloc0_adata, alloc1_adata, upd0_adata, upd1_adata;
    logic [1:0] ret_req;
    logic       alloc0_gnt, alloc1_gnt, wrt0_en, wrt1_en, full, empty;
    logic [5:0] alloc0_WQ, alloc1_WQ, wrt0_WQ, wrt1_WQ, upd0_WQ, upd1_WQ;
    logic [4:0] wrt0_adata, wrt1_adata;
    logic [1:0] ret_vld, ret_cnt;
    logic [6:0] count;
`ifdef STQ_ADATA_CTL_PERF_EN
    logic [31:0] perf_stall, perf_alloc;
    logic [15:0] perf_flush;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stq_adata_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .alloc0_req   (alloc0_req),
        .alloc0_adata (alloc0_adata),
        .alloc1_req   (alloc1_req),
        .alloc1_adata (alloc1_adata),
        .flush        (flush),
        .ret_req      (ret_req),
        .upd0_adata   (upd0_adata),
        .upd1_adata   (upd1_adata),
        .alloc0_gnt   (alloc0_gnt),
        .alloc1_gnt   (alloc1_gnt),
        .alloc0_WQ    (alloc0_WQ),
        .alloc1_WQ    (alloc1_WQ),
        .wrt0_en      (wrt0_en),
        .wrt0_WQ      (wrt0_WQ),
        .wrt0_adata   (wrt0_adata),
        .wrt1_en      (wrt1_en),
        .wrt1_WQ      (wrt1_WQ),
        .wrt1_adata   (wrt1_adata),
        .upd0_WQ      (upd0_WQ),
        .upd1_WQ      (upd1_WQ),
        .ret_vld      (ret_vld),
        .ret_cnt      (ret_cnt),
        .count        (count),
        .full         (full),
        .empty        (empty)
`ifdef STQ_ADATA_CTL_PERF_EN
        ,
        .perf_stall   (perf_stall),
        .perf_alloc   (perf_alloc),
        .perf_flush   (perf_flush)
`endif
    );

    typedef struct {
        logic       a0, a1;
        logic [4:0] ad0, ad1;
        logic       eg0, eg1;
        logic [5:0] ewq0, ewq1;
        logic [6:0] ecnt;
        logic       efull;
        logic       ewen;
        logic [5:0] ew0wq, ew1wq;
        logic [4:0] ew0ad, ew1ad;
    } vec_t;

    vec_t tbl[34];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic a0, input logic a1, input logic fl, input logic [1:0] rr);
        alloc0_req   = a0;
        alloc1_req   = a1;
        flush        = fl;
        ret_req      = rr;
    endtask

    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [4:0] k5;
        rst = 1'b0;
        alloc0_adata = '0;
        alloc1_adata = '0;
        upd0_adata   = 5'h0A;
        upd1_adata   = 5'h15;
        drive(1'b0, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < 34; i++) begin
            k5 = 5'(i);
            tbl[i].a0    = (i < 33);
            tbl[i].a1    = (i < 33);
            tbl[i].ad0   = k5;
            tbl[i].ad1   = ~k5;
            tbl[i].eg0   = (i < 32);
            tbl[i].eg1   = (i < 32);
            tbl[i].ewq0  = 6'(2 * i);
            tbl[i].ewq1  = 6'(2 * i + 1);
            tbl[i].ecnt  = (i < 32) ? 7'(2 * i) : 7'd64;
            tbl[i].efull = (i >= 32);
            tbl[i].ewen  = (i > 0) && (i < 33);
            tbl[i].ew0wq = 6'(2 * (i - 1));
            tbl[i].ew1wq = 6'(2 * (i - 1) + 1);
            tbl[i].ew0ad = 5'(i - 1);
            tbl[i].ew1ad = ~5'(i - 1);
        end

        // reset state
        repeat (2) @(posedge clk);
        to_negedge();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wrt0_en", 32'(wrt0_en), 32'd0);
        chk("rst_wrt1_en", 32'(wrt1_en), 32'd0);
        chk("rst_ret_cnt", 32'(ret_cnt), 32'd0);
        commit();
        rst = 1'b1;

        // fill to full with both lanes, then requests past full
        for (int i = 0; i < 34; i++) begin
            drive(tbl[i].a0, tbl[i].a1, 1'b0, 2'd0);
            alloc0_adata = tbl[i].ad0;
            alloc1_adata = tbl[i].ad1;
            to_negedge();
            chk($sformatf("fill%0d_gnt0", i), 32'(alloc0_gnt), 32'(tbl[i].eg0));
            chk($sformatf("fill%0d_gnt1", i), 32'(alloc1_gnt), 32'(tbl[i].eg1));
            chk($sformatf("fill%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("fill%0d_full", i), 32'(full), 32'(tbl[i].efull));
            chk($sformatf("fill%0d_wrt0_en", i), 32'(wrt0_en), 32'(tbl[i].ewen));
            chk($sformatf("fill%0d_wrt1_en", i), 32'(wrt1_en), 32'(tbl[i].ewen));
            if (tbl[i].eg0) chk($sformatf("fill%0d_wq0", i), 32'(alloc0_WQ), 32'(tbl[i].ewq0));
            if (tbl[i].eg1) chk($sformatf("fill%0d_wq1", i), 32'(alloc1_WQ), 32'(tbl[i].ewq1));
            if (tbl[i].ewen) begin
                chk($sformatf("fill%0d_wrt0_wq", i), 32'(wrt0_WQ), 32'(tbl[i].ew0wq));
                chk($sformatf("fill%0d_wrt1_wq", i), 32'(wrt1_WQ), 32'(tbl[i].ew1wq));
                chk($sformatf("fill%0d_wrt0_ad", i), 32'(wrt0_adata), 32'(tbl[i].ew0ad));
                chk($sformatf("fill%0d_wrt1_ad", i), 32'(wrt1_adata), 32'(tbl[i].ew1ad));
            end
            commit();
        end

        // count 64 -> retire one -> count 63 corner cases
        drive(1'b0, 1'b0, 1'b0, 2'd1);
        to_negedge();
        chk("full_ret_vld", 32'(ret_vld), 32'd3);
        chk("full_ret1_cnt", 32'(ret_cnt), 32'd1);
        commit();
        drive(1'b1, 1'b1, 1'b0, 2'd1);
        to_negedge();
        chk("c63_both_count", 32'(count), 32'd63);
        chk("c63_both_gnt0", 32'(alloc0_gnt), 32'd1);
        chk("c63_both_gnt1", 32'(alloc1_gnt), 32'd0);
        chk("c63_both_wq0", 32'(alloc0_WQ), 32'd0);
        commit();
        drive(1'b0, 1'b1, 1'b0, 2'd0);
        to_negedge();
        chk("c63_one_count", 32'(count), 32'd63);
        chk("c63_one_gnt1", 32'(alloc1_gnt), 32'd1);
        chk("c63_one_wq1", 32'(alloc1_WQ), 32'd1);
        commit();
        drive(1'b1, 1'b0, 1'b0, 2'd2);
        to_negedge();
        chk("full_ret_full", 32'(full), 32'd1);
        chk("full_ret_gnt0", 32'(alloc0_gnt), 32'd0);
        chk("full_ret_cnt", 32'(ret_cnt), 32'd2);
        commit();
        chk("full_ret_after_count", 32'(count), 32'd62);

        // retire must wait for the write stage of WQ 5
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 2'd0); commit();
        drive(1'b1, 1'b1, 1'b0, 2'd0); commit();
        drive(1'b1, 1'b0, 1'b0, 2'd2); to_negedge();
        chk("wq5_r01", 32'(ret_cnt), 32'd2); commit();
        drive(1'b0, 1'b0, 1'b0, 2'd2); to_negedge();
        chk("wq5_r23", 32'(ret_cnt), 32'd2); commit();
        drive(1'b1, 1'b0, 1'b0, 2'd1); to_negedge();
        chk("wq5_alloc_wq", 32'(alloc0_WQ), 32'd5);
        chk("wq5_r4", 32'(ret_cnt), 32'd1); commit();
        drive(1'b0, 1'b0, 1'b0, 2'd2); to_negedge();
        chk("wq5_wrt_en", 32'(wrt0_en), 32'd1);
        chk("wq5_wrt_wq", 32'(wrt0_WQ), 32'd5);
        chk("wq5_upd0", 32'(upd0_WQ), 32'd5);
        chk("wq5_early_ret", 32'(ret_cnt), 32'd0); commit();
        to_negedge();
        chk("wq5_ret_vld", 32'(ret_vld), 32'd1);
        chk("wq5_late_ret", 32'(ret_cnt), 32'd1); commit();
        chk("wq5_head", 32'(upd0_WQ), 32'd6);
        chk("wq5_empty", 32'(empty), 32'd1);

        // wrap-around from head=tail=62
        do_reset();
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'd2); commit();
        end
        drive(1'b0, 1'b0, 1'b0, 2'd2);
        for (int k = 0; k < 40 && !empty; k++) commit();
        chk("wrap_drained", 32'(empty), 32'd1);
        chk("wrap_head62", 32'(upd0_WQ), 32'd62);
        drive(1'b1, 1'b1, 1'b0, 2'd0); to_negedge();
        chk("wrap_wq62", 32'(alloc0_WQ), 32'd62);
        chk("wrap_wq63", 32'(alloc1_WQ), 32'd63); commit();
        drive(1'b1, 1'b1, 1'b0, 2'd0); to_negedge();
        chk("wrap_wq0", 32'(alloc0_WQ), 32'd0);
        chk("wrap_wq1", 32'(alloc1_WQ), 32'd1); commit();
        drive(1'b0, 1'b0, 1'b0, 2'd2); to_negedge();
        chk("wrap_upd1", 32'(upd1_WQ), 32'd63);
        chk("wrap_ret2", 32'(ret_cnt), 32'd2); commit();
        drive(1'b0, 1'b0, 1'b0, 2'd0); to_negedge();
        chk("wrap_upd0_0", 32'(upd0_WQ), 32'd0);
        chk("wrap_upd1_1", 32'(upd1_WQ), 32'd1);
        chk("wrap_count2", 32'(count), 32'd2);
        commit();

        // flush with a retire and a pending write
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'd0); commit();
        end
        drive(1'b1, 1'b1, 1'b1, 2'd1); to_negedge();
        chk("fl_count10", 32'(count), 32'd10);
        chk("fl_ret_cnt", 32'(ret_cnt), 32'd1);
        chk("fl_wrt0_sq", 32'(wrt0_en), 32'd0);
        chk("fl_wrt1_sq", 32'(wrt1_en), 32'd0);
        chk("fl_gnt0", 32'(alloc0_gnt), 32'd0); commit();
        drive(1'b1, 1'b1, 1'b0, 2'd2); to_negedge();
        chk("fls_count", 32'(count), 32'd0);
        chk("fls_empty", 32'(empty), 32'd1);
        chk("fls_gnt0", 32'(alloc0_gnt), 32'd0);
        chk("fls_gnt1", 32'(alloc1_gnt), 32'd0);
        chk("fls_wrt0", 32'(wrt0_en), 32'd0);
        chk("fls_ret_cnt", 32'(ret_cnt), 32'd0); commit();
        drive(1'b1, 1'b1, 1'b0, 2'd0); to_negedge();
        chk("post_fl_gnt0", 32'(alloc0_gnt), 32'd1);
        chk("post_fl_wq0", 32'(alloc0_WQ), 32'd1);
        chk("post_fl_wq1", 32'(alloc1_WQ), 32'd2); commit();
        drive(1'b0, 1'b0, 1'b0, 2'd2); to_negedge();
        chk("post_fl_wrt_wq", 32'(wrt0_WQ), 32'd1);
        chk("post_fl_stale", 32'(ret_cnt), 32'd0); commit();

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'd0); commit();
        end
        drive(1'b0, 1'b0, 1'b0, 2'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_wrt0", 32'(wrt0_en), 32'd0);
        chk("arst_wrt1", 32'(wrt1_en), 32'd0);
        chk("arst_ret_cnt", 32'(ret_cnt), 32'd0);
        commit();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'd0); to_negedge();
        chk("arst_first_gnt", 32'(alloc0_gnt), 32'd1);
        chk("arst_first_wq", 32'(alloc0_WQ), 32'd0);
        commit();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
